// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: pixel-enable divider, h/v counters, registered decode.
// Latency: outputs describe the new pixel on the same edge the counters advance.
// Backpressure: none; consumers sample x/y/DE continuously and gate on DE.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       DE,
    output logic       h_sync,
    output logic       v_sync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] hn;
    logic [9:0] vn;
    logic       tick;
    logic       h_wrap;

    // Outputs decode the next position so every output lands on the same pixel.
    always_comb begin
        tick   = (div_cnt == DIV_LAST);
        h_wrap = (h_cnt == H_LAST);
        hn     = h_wrap ? 10'd0 : h_cnt + 10'd1;
        vn     = v_cnt;
        if (h_wrap) begin
            vn = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Counters reset to the last raster position so the first tick enters (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= 4'd0;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            DE          <= 1'b0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
        end else begin
            div_cnt     <= tick ? 4'd0 : div_cnt + 4'd1;
            pix_tick    <= tick;
            frame_start <= tick && (hn == 10'd0) && (vn == 10'd0);
            if (tick) begin
                h_cnt  <= hn;
                v_cnt  <= vn;
                x      <= hn;
                y      <= vn;
                DE     <= (hn < H_VIS) && (vn < V_VIS);
                h_sync <= !((hn >= HS_BEG) && (hn < HS_END));
                v_sync <= !((vn >= VS_BEG) && (vn < VS_END));
            end
        end
    end

endmodule
